// File: rtl/key_serializer_pkg.sv
// Shared constants and width helpers for the keypad serializer.
package key_serializer_pkg;

    localparam int KEY_W_DEF        = 8;
    localparam int DEBOUNCE_CYC_DEF = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int max_count);
        int w;
        w = clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_serializer_if.sv
// Key/strobe inputs and serial/status outputs between board logic and the serializer.
interface key_serializer_if #(
    parameter int KEY_W = 8,
    parameter int PORTS = 1
);
    logic [PORTS*KEY_W-1:0] key;
    logic                   load;
    logic                   shift;
    logic [PORTS-1:0]       skey;
    logic [PORTS-1:0]       empty;
    logic                   changed;

    modport master (output key, load, shift, input skey, empty, changed);
    modport slave  (input key, load, shift, output skey, empty, changed);
endinterface

// File: rtl/key_serializer_debounce.sv
// One key bit: two-flop synchroniser followed by a persistence filter.
module key_serializer_debounce
    import key_serializer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_i,
    output logic deb_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            assign deb_o = sync2_q;
        end else begin : g_filter
            localparam int CW = cnt_width(DEBOUNCE_CYC);
            logic [CW-1:0] cnt_q;
            logic          deb_q;

            // Any return to the accepted value restarts the persistence count.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                    deb_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign deb_o = deb_q;
        end
    endgenerate

endmodule

// File: rtl/key_serializer.sv
// Keypad front end: debounced keys snapshot on a load rising edge, then shifted out per port.
module key_serializer
    import key_serializer_pkg::*;
#(
    parameter int KEY_W        = KEY_W_DEF,
    parameter int PORTS        = 1,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit FILL         = 1'b0
) (
    input logic              clk,
    input logic              rstn,
    key_serializer_if.slave  bus
);

    localparam int BW = cnt_width(KEY_W);

    logic [PORTS*KEY_W-1:0] deb;
    logic [PORTS*KEY_W-1:0] prev_q;
    logic                   load_q;
    logic                   changed_q;
    logic                   ld;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS*KEY_W; gi++) begin : g_deb
            key_serializer_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_deb (
                .clk  (clk),
                .rstn (rstn),
                .key_i(bus.key[gi]),
                .deb_o(deb[gi])
            );
        end
    endgenerate

    assign ld = bus.load & ~load_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q    <= 1'b0;
            prev_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            load_q    <= bus.load;
            changed_q <= 1'b0;
            if (ld) begin
                prev_q    <= deb;
                changed_q <= (deb != prev_q);
            end
        end
    end

    assign bus.changed = changed_q;

    genvar gp;
    generate
        for (gp = 0; gp < PORTS; gp++) begin : g_port
            logic [KEY_W-1:0] sr_q;
            logic [KEY_W-1:0] sr_shifted;
            logic [BW-1:0]    bits_q;

            if (MSB_FIRST) begin : g_msb
                assign sr_shifted = {sr_q[KEY_W-2:0], FILL};
                assign bus.skey[gp] = sr_q[KEY_W-1];
            end else begin : g_lsb
                assign sr_shifted = {FILL, sr_q[KEY_W-1:1]};
                assign bus.skey[gp] = sr_q[0];
            end

            // A load edge wins over a coincident shift; shifting past empty streams FILL.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sr_q   <= '0;
                    bits_q <= '0;
                end else if (ld) begin
                    sr_q   <= deb[gp*KEY_W +: KEY_W];
                    bits_q <= BW'(KEY_W);
                end else if (bus.shift) begin
                    sr_q <= sr_shifted;
                    if (bits_q != '0) begin
                        bits_q <= bits_q - BW'(1);
                    end
                end
            end

            assign bus.empty[gp] = (bits_q == '0);
        end
    endgenerate

endmodule

// File: tb/tb_key_serializer.sv
// Directed bench: single-port MSB-first instance plus a two-port LSB-first FILL=1 instance.
module tb_key_serializer;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    key_serializer_if #(.KEY_W(8), .PORTS(1)) b0 ();
    key_serializer_if #(.KEY_W(8), .PORTS(2)) b1 ();

    key_serializer #(
        .KEY_W(8), .PORTS(1), .DEBOUNCE_CYC(4), .MSB_FIRST(1'b1), .FILL(1'b0)
    ) u_dut0 (
        .clk (clk),
        .rstn(rstn),
        .bus (b0)
    );

    key_serializer #(
        .KEY_W(8), .PORTS(2), .DEBOUNCE_CYC(4), .MSB_FIRST(1'b0), .FILL(1'b1)
    ) u_dut1 (
        .clk (clk),
        .rstn(rstn),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load0();
        b0.load = 1'b1;
        tick(1);
        b0.load = 1'b0;
    endtask

    // Checks eight MSB-first bits of v on dut0, shifting after each, then the empty flag.
    task automatic shift8(input string tag, input logic [7:0] v);
        logic [7:0] val;
        val = v;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_skey"}, 32'(b0.skey), 32'(val[7-i]));
            chk({tag, "_notempty"}, 32'(b0.empty), 32'd0);
            b0.shift = 1'b1;
            tick(1);
        end
        b0.shift = 1'b0;
        chk({tag, "_empty"}, 32'(b0.empty), 32'd1);
        chk({tag, "_fill"}, 32'(b0.skey), 32'd0);
    endtask

    initial begin
        logic [7:0] p0v;
        logic [7:0] p1v;
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        b0.key   = '0;
        b0.load  = 1'b0;
        b0.shift = 1'b0;
        b1.key   = '0;
        b1.load  = 1'b0;
        b1.shift = 1'b0;
        tick(3);
        chk("rst_skey", 32'(b0.skey), 32'd0);
        chk("rst_empty", 32'(b0.empty), 32'd1);
        chk("rst_changed", 32'(b0.changed), 32'd0);
        chk("rst_empty_p2", 32'(b1.empty), 32'd3);
        rstn = 1'b1;
        tick(2);

        // A5 stable, load, eight shifts
        b0.key = 8'hA5;
        tick(10);
        do_load0();
        chk("a5_changed", 32'(b0.changed), 32'd1);
        shift8("a5", 8'hA5);
        chk("a5_changed_clr", 32'(b0.changed), 32'd0);

        // 3-cycle glitch on bit 0 is rejected
        b0.key = 8'hA4;
        tick(3);
        b0.key = 8'hA5;
        tick(10);
        do_load0();
        chk("glitch3_changed", 32'(b0.changed), 32'd0);
        shift8("glitch3", 8'hA5);

        // 4-cycle pulse is accepted; load while the filtered value is A4
        b0.key = 8'hA4;
        tick(4);
        b0.key = 8'hA5;
        tick(2);
        do_load0();
        chk("pulse4_changed", 32'(b0.changed), 32'd1);
        shift8("pulse4", 8'hA4);
        tick(10);

        // load and shift rise together; load then held high for 20 cycles
        b0.key = 8'h5A;
        tick(10);
        b0.load  = 1'b1;
        b0.shift = 1'b1;
        tick(1);
        shift8("ldsh", 8'h5A);
        tick(11);
        chk("held_no_reload", 32'(b0.empty), 32'd1);
        b0.load = 1'b0;
        tick(1);

        // F0, three shifts, then reload with 0F
        b0.key = 8'hF0;
        tick(10);
        do_load0();
        for (int i = 0; i < 3; i++) begin
            chk("f0_skey", 32'(b0.skey), 32'd1);
            b0.shift = 1'b1;
            tick(1);
        end
        b0.shift = 1'b0;
        chk("f0_bits_left", 32'(b0.empty), 32'd0);
        b0.key = 8'h0F;
        tick(10);
        do_load0();
        chk("reload_changed", 32'(b0.changed), 32'd1);
        tick(1);
        chk("reload_changed_once", 32'(b0.changed), 32'd0);
        shift8("reload", 8'h0F);

        // Asynchronous reset in the middle of a frame
        do_load0();
        b0.shift = 1'b1;
        tick(4);
        b0.shift = 1'b0;
        chk("mid_skey_pre", 32'(b0.skey), 32'd1);
        chk("mid_empty_pre", 32'(b0.empty), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_skey", 32'(b0.skey), 32'd0);
        chk("mid_rst_empty", 32'(b0.empty), 32'd1);
        chk("mid_rst_changed", 32'(b0.changed), 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(2);

        // Two ports, LSB first, FILL=1
        b1.key = 16'h8001;
        tick(10);
        b1.load = 1'b1;
        tick(1);
        b1.load = 1'b0;
        chk("p2_changed", 32'(b1.changed), 32'd1);
        p0v = 8'h01;
        p1v = 8'h80;
        for (int i = 0; i < 8; i++) begin
            chk("p2_skey", 32'(b1.skey), 32'({p1v[i], p0v[i]}));
            chk("p2_notempty", 32'(b1.empty), 32'd0);
            b1.shift = 1'b1;
            tick(1);
        end
        chk("p2_empty", 32'(b1.empty), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("p2_fill", 32'(b1.skey), 32'd3);
            tick(1);
        end
        b1.shift = 1'b0;
        chk("p2_empty_stays", 32'(b1.empty), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
